// File: rtl/avr_cpu_mul_if.sv
// avr_cpu_mul_if: issue/response bundle between the AVR control unit and the
// multi-cycle multiplier. The control unit is the master: it drives operands
// and the start pulse, and receives busy/done plus the product and new SREG.
interface avr_cpu_mul_if;
    logic        start;
    logic [1:0]  mode;
    logic        frac;
    logic [7:0]  d_in;
    logic [7:0]  r_in;
    logic [7:0]  status_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [7:0]  status_out;

    modport master (
        output start, mode, frac, d_in, r_in, status_in,
        input  busy, done, result, status_out
    );

    modport slave (
        input  start, mode, frac, d_in, r_in, status_in,
        output busy, done, result, status_out
    );
endinterface

// File: rtl/avr_cpu_mul.sv
// avr_cpu_mul: 8x8 multiplier for the AVR MUL/MULS/MULSU/FMUL/FMULS/FMULSU group.
// Operands are reduced to magnitudes on issue, multiplied unsigned, and the
// product is conditionally negated at the end. The default build uses an
// 8-cycle shift-add datapath (one multiplier bit per cycle). Defining
// AVR_CPU_MUL_FAST_EN collapses CALC to a single cycle with a combinational
// multiply; results and flags are identical in both builds.
module avr_cpu_mul #(
    parameter int ITER_BITS = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    avr_cpu_mul_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        last_iter;

    logic        d_neg;
    logic        r_neg;
    logic [7:0]  d_mag;
    logic [7:0]  r_mag;

    logic        frac_q;
    logic        neg_q;
    logic [7:0]  status_q;
    logic [15:0] mcand_q;
    logic [7:0]  mplier_q;
    logic [15:0] result_q;
    logic [7:0]  status_out_q;

    logic [15:0] acc_next;
    logic [15:0] prod;
    logic [15:0] res_next;
    logic [7:0]  status_next;

`ifdef AVR_CPU_MUL_FAST_EN
    assign last_iter = 1'b1;
`else
    logic [ITER_BITS-1:0] iter_q;
    logic [15:0]          acc_q;

    assign last_iter = (iter_q == ITER_BITS'(7));
`endif

    // Sign handling at issue: mode 01 signs both operands, mode 10 signs only d, mode 11 behaves as 00
    always_comb begin
        d_neg = 1'b0;
        r_neg = 1'b0;
        if ((bus.mode == 2'b01) || (bus.mode == 2'b10)) begin
            d_neg = bus.d_in[7];
        end
        if (bus.mode == 2'b01) begin
            r_neg = bus.r_in[7];
        end
        d_mag = d_neg ? (~bus.d_in + 8'd1) : bus.d_in;
        r_mag = r_neg ? (~bus.r_in + 8'd1) : bus.r_in;
    end

    // Product assembly: accumulate, restore sign, apply fractional shift and derive C/Z
    always_comb begin
`ifdef AVR_CPU_MUL_FAST_EN
        acc_next = mcand_q * {8'h00, mplier_q};
`else
        acc_next = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
`endif
        prod        = neg_q ? (~acc_next + 16'd1) : acc_next;
        res_next    = frac_q ? {prod[14:0], 1'b0} : prod;
        status_next = {status_q[7:2], (res_next == 16'h0000), prod[15]};
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: new work is only taken in IDLE or DONE, never mid-calculation
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture on accept, one shift-add step per CALC cycle, outputs updated on entry to DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frac_q       <= 1'b0;
            neg_q        <= 1'b0;
            status_q     <= 8'h00;
            mcand_q      <= 16'h0000;
            mplier_q     <= 8'h00;
            result_q     <= 16'h0000;
            status_out_q <= 8'h00;
`ifndef AVR_CPU_MUL_FAST_EN
            acc_q        <= 16'h0000;
            iter_q       <= '0;
`endif
        end else if (accept) begin
            frac_q   <= bus.frac;
            neg_q    <= d_neg ^ r_neg;
            status_q <= bus.status_in;
            mcand_q  <= {8'h00, d_mag};
            mplier_q <= r_mag;
`ifndef AVR_CPU_MUL_FAST_EN
            acc_q    <= 16'h0000;
            iter_q   <= '0;
`endif
        end else if (state == CALC) begin
`ifndef AVR_CPU_MUL_FAST_EN
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            iter_q   <= iter_q + ITER_BITS'(1);
`endif
            if (last_iter) begin
                result_q     <= res_next;
                status_out_q <= status_next;
            end
        end
    end

    assign bus.busy       = (state == CALC);
    assign bus.done       = (state == DONE);
    assign bus.result     = result_q;
    assign bus.status_out = status_out_q;

endmodule

// File: tb/tb_avr_cpu_mul.sv
// tb_avr_cpu_mul: directed vectors for avr_cpu_mul. Issued operations push the
// hand-computed product, SREG and expected done cycle into a scoreboard; a
// monitor on the falling edge pops and compares whenever done is seen.
module tb_avr_cpu_mul;

`ifdef AVR_CPU_MUL_FAST_EN
    localparam int LAT     = 2;
    localparam int IGN_CYC = 1;
    localparam int RST_CYC = 1;
`else
    localparam int LAT     = 9;
    localparam int IGN_CYC = 4;
    localparam int RST_CYC = 5;
`endif

    typedef struct {
        logic [15:0] res;
        logic [7:0]  st;
        int          cyc;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       reset_n;
    int         total = 0;
    int         bad = 0;
    int         neg_cnt = 0;
    sb_entry_t  sb[$];
    sb_entry_t  cur;

    avr_cpu_mul_if mul_bus();

    avr_cpu_mul dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (mul_bus)
    );

    // Free-running core clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one issue request; optionally record the expected response at the accept edge
    task automatic applyStimulus(input logic [1:0] mode, input logic frac,
                                 input logic [7:0] d, input logic [7:0] r, input logic [7:0] st,
                                 input logic expect_done, input logic [15:0] exp_res, input logic [7:0] exp_st);
        sb_entry_t e;
        mul_bus.mode      = mode;
        mul_bus.frac      = frac;
        mul_bus.d_in      = d;
        mul_bus.r_in      = r;
        mul_bus.status_in = st;
        mul_bus.start     = 1'b1;
        @(posedge clk);
        if (expect_done) begin
            e.res = exp_res;
            e.st  = exp_st;
            e.cyc = neg_cnt + LAT - 1;
            sb.push_back(e);
        end
        #1;
        mul_bus.start = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        checkOutput("drain_pending", sb.size(), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic runOp(input logic [1:0] mode, input logic frac,
                         input logic [7:0] d, input logic [7:0] r, input logic [7:0] st,
                         input logic [15:0] exp_res, input logic [7:0] exp_st);
        applyStimulus(mode, frac, d, r, st, 1'b1, exp_res, exp_st);
        waitDrain();
    endtask

    // Monitor: compare every done pulse against the oldest scoreboard entry
    always @(negedge clk) begin
        neg_cnt <= neg_cnt + 1;
        if (mul_bus.done === 1'b1) begin
            checkOutput("busy_with_done", mul_bus.busy, 0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", neg_cnt);
            end else begin
                cur = sb.pop_front();
                checkOutput("result", mul_bus.result, cur.res);
                checkOutput("status_out", mul_bus.status_out, cur.st);
                checkOutput("done_cycle", neg_cnt, cur.cyc);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        reset_n           = 1'b0;
        mul_bus.start     = 1'b0;
        mul_bus.mode      = 2'b00;
        mul_bus.frac      = 1'b0;
        mul_bus.d_in      = 8'h00;
        mul_bus.r_in      = 8'h00;
        mul_bus.status_in = 8'h00;

        @(negedge clk);
        checkOutput("reset_busy", mul_bus.busy, 0);
        checkOutput("reset_done", mul_bus.done, 0);
        checkOutput("reset_result", mul_bus.result, 16'h0000);
        checkOutput("reset_status", mul_bus.status_out, 8'h00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] unsigned 0xFF*0xFF");
        applyStimulus(2'b00, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b1, 16'hFE01, 8'h01);
        checkOutput("busy_cycle1", mul_bus.busy, 1);
        checkOutput("done_cycle1", mul_bus.done, 0);
        waitDrain();

        $display("[TB] signed and mixed-sign products");
        runOp(2'b01, 1'b0, 8'h80, 8'h80, 8'h00, 16'h4000, 8'h00);
        runOp(2'b01, 1'b0, 8'hFF, 8'h01, 8'h00, 16'hFFFF, 8'h01);
        runOp(2'b01, 1'b0, 8'hFE, 8'h03, 8'h00, 16'hFFFA, 8'h01);
        runOp(2'b10, 1'b0, 8'hFF, 8'h02, 8'h00, 16'hFFFE, 8'h01);
        runOp(2'b10, 1'b0, 8'h02, 8'hFF, 8'h00, 16'h01FE, 8'h00);
        runOp(2'b11, 1'b0, 8'hFF, 8'hFF, 8'h00, 16'hFE01, 8'h01);

        $display("[TB] fractional variants");
        runOp(2'b00, 1'b1, 8'h40, 8'h40, 8'h00, 16'h2000, 8'h00);
        runOp(2'b01, 1'b1, 8'h80, 8'h80, 8'h00, 16'h8000, 8'h00);
        runOp(2'b00, 1'b1, 8'h80, 8'h02, 8'h00, 16'h0200, 8'h00);
        runOp(2'b10, 1'b1, 8'hC0, 8'h40, 8'h00, 16'hE000, 8'h01);
        runOp(2'b00, 1'b1, 8'hFF, 8'h81, 8'h00, 16'h00FE, 8'h01);

        $display("[TB] SREG pass-through and zero flag");
        runOp(2'b00, 1'b0, 8'h02, 8'h03, 8'hFF, 16'h0006, 8'hFC);
        runOp(2'b00, 1'b1, 8'h80, 8'h00, 8'h00, 16'h0000, 8'h02);

        $display("[TB] zero product with start pulse during CALC");
        applyStimulus(2'b00, 1'b0, 8'h00, 8'h37, 8'hC0, 1'b1, 16'h0000, 8'hC2);
        repeat (IGN_CYC - 1) @(posedge clk);
        #1;
        applyStimulus(2'b01, 1'b0, 8'h11, 8'h22, 8'h3C, 1'b0, 16'h0000, 8'h00);
        waitDrain();

        $display("[TB] back-to-back issue from DONE");
        applyStimulus(2'b00, 1'b0, 8'h12, 8'h34, 8'h00, 1'b1, 16'h03A8, 8'h00);
        repeat (LAT - 1) @(posedge clk);
        #1;
        applyStimulus(2'b01, 1'b0, 8'hFE, 8'h03, 8'h00, 1'b1, 16'hFFFA, 8'h01);
        waitDrain();

        $display("[TB] reset during CALC");
        applyStimulus(2'b00, 1'b0, 8'h12, 8'h34, 8'h00, 1'b0, 16'h0000, 8'h00);
        repeat (RST_CYC - 1) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", mul_bus.busy, 0);
        checkOutput("abort_done", mul_bus.done, 0);
        checkOutput("abort_result", mul_bus.result, 16'h0000);
        checkOutput("abort_status", mul_bus.status_out, 8'h00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        runOp(2'b00, 1'b0, 8'h12, 8'h34, 8'h00, 16'h03A8, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
